// File: rtl/tri_bbox_scanner.sv
// Triangle bounding-box scanner: latches a triangle, clips its integer bbox to the screen,
// then walks the box row-major one pixel per cycle. Optional macro: TRI_BBOX_PIXEL_CENTER_EN.
module tri_bbox_scanner #(
  parameter int XWIDTH     = 24,
  parameter int YWIDTH     = 24,
  parameter int FRAC       = 14,
  parameter int AINV_WIDTH = 16,
  parameter int HRES       = 320,
  parameter int VRES       = 180,
  parameter int HBITS      = $clog2(HRES),
  parameter int VBITS      = $clog2(VRES)
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          freeze,
  input  logic                          tri_valid_in,
  output logic                          tri_ready_out,
  input  logic [2:0][XWIDTH-1:0]        x_tri_in,
  input  logic [2:0][YWIDTH-1:0]        y_tri_in,
  input  logic [AINV_WIDTH-1:0]         iarea_in,
  output logic [XWIDTH-1:0]             x_out,
  output logic [YWIDTH-1:0]             y_out,
  output logic [HBITS-1:0]              hcount_out,
  output logic [VBITS-1:0]              vcount_out,
  output logic [2:0][XWIDTH-1:0]        x_tri_out,
  output logic [2:0][YWIDTH-1:0]        y_tri_out,
  output logic [AINV_WIDTH-1:0]         iarea_out,
  output logic                          pix_valid_out,
  output logic                          last_out
);

  // state | meaning
  // IDLE  | waiting for a triangle handshake
  // SETUP | vertices latched, computing min/max
  // CLIP  | flooring/clamping bbox, empty check
  // SCAN  | emitting one pixel per cycle
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_CLIP, S_SCAN} state_t;

  if ((XWIDTH - FRAC - 1) < HBITS || (YWIDTH - FRAC - 1) < VBITS) begin : g_width_err
    $error("tri_bbox_scanner: integer part of x/y too narrow for HRES/VRES");
  end

  localparam logic signed [XWIDTH-1:0] XLIM = XWIDTH'(HRES - 1);
  localparam logic signed [YWIDTH-1:0] YLIM = YWIDTH'(VRES - 1);

  function automatic logic signed [XWIDTH-1:0] min3x(input logic [2:0][XWIDTH-1:0] v, input logic want_max);
    logic signed [XWIDTH-1:0] m;
    m = $signed(v[0]);
    for (int i = 1; i < 3; i++)
      if (want_max ? ($signed(v[i]) > m) : ($signed(v[i]) < m)) m = $signed(v[i]);
    return m;
  endfunction

  function automatic logic signed [YWIDTH-1:0] min3y(input logic [2:0][YWIDTH-1:0] v, input logic want_max);
    logic signed [YWIDTH-1:0] m;
    m = $signed(v[0]);
    for (int i = 1; i < 3; i++)
      if (want_max ? ($signed(v[i]) > m) : ($signed(v[i]) < m)) m = $signed(v[i]);
    return m;
  endfunction

  state_t r_state, w_next;
  logic [2:0][XWIDTH-1:0]   r_x_tri;
  logic [2:0][YWIDTH-1:0]   r_y_tri;
  logic [AINV_WIDTH-1:0]    r_iarea;
  logic signed [XWIDTH-1:0] r_xmin, r_xmax;
  logic signed [YWIDTH-1:0] r_ymin, r_ymax;
  logic [HBITS-1:0]         r_xlo, r_xhi, r_hcount;
  logic [VBITS-1:0]         r_yhi, r_vcount;

  logic signed [XWIDTH-1:0] w_xmin_i, w_xmax_i;
  logic signed [YWIDTH-1:0] w_ymin_i, w_ymax_i;
  logic [HBITS-1:0]         w_xlo, w_xhi;
  logic [VBITS-1:0]         w_ylo, w_yhi;
  logic                     w_empty, w_accept, w_h_end, w_v_end;
  logic [XWIDTH-1:0]        w_x_fix;
  logic [YWIDTH-1:0]        w_y_fix;

  assign tri_ready_out = (r_state == S_IDLE) && !freeze;
  assign w_accept      = tri_valid_in && tri_ready_out;

  assign w_xmin_i = r_xmin >>> FRAC;
  assign w_xmax_i = r_xmax >>> FRAC;
  assign w_ymin_i = r_ymin >>> FRAC;
  assign w_ymax_i = r_ymax >>> FRAC;

  assign w_empty = w_xmax_i[XWIDTH-1] || w_ymax_i[YWIDTH-1] ||
                   (w_xmin_i > XLIM) || (w_ymin_i > YLIM) || (r_iarea == '0);

  // Lower clamp only needs the sign bit; an over-range min is already caught by w_empty.
  assign w_xlo = w_xmin_i[XWIDTH-1] ? '0 : w_xmin_i[HBITS-1:0];
  assign w_ylo = w_ymin_i[YWIDTH-1] ? '0 : w_ymin_i[VBITS-1:0];
  assign w_xhi = (w_xmax_i > XLIM) ? XLIM[HBITS-1:0] : w_xmax_i[HBITS-1:0];
  assign w_yhi = (w_ymax_i > YLIM) ? YLIM[VBITS-1:0] : w_ymax_i[VBITS-1:0];

  assign w_h_end = (r_hcount == r_xhi);
  assign w_v_end = (r_vcount == r_yhi);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)    r_state <= S_IDLE;
    else if (!freeze) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      S_SETUP: w_next = S_CLIP;
      S_CLIP:  w_next = w_empty ? S_IDLE : S_SCAN;
      S_SCAN:  if (w_h_end && w_v_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x_tri  <= '0;
      r_y_tri  <= '0;
      r_iarea  <= '0;
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymin   <= '0;
      r_ymax   <= '0;
      r_xlo    <= '0;
      r_xhi    <= '0;
      r_yhi    <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (!freeze) begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_x_tri <= x_tri_in;
          r_y_tri <= y_tri_in;
          r_iarea <= iarea_in;
        end
        S_SETUP: begin
          r_xmin <= min3x(r_x_tri, 1'b0);
          r_xmax <= min3x(r_x_tri, 1'b1);
          r_ymin <= min3y(r_y_tri, 1'b0);
          r_ymax <= min3y(r_y_tri, 1'b1);
        end
        S_CLIP: begin
          r_xlo    <= w_xlo;
          r_xhi    <= w_xhi;
          r_yhi    <= w_yhi;
          r_hcount <= w_xlo;
          r_vcount <= w_ylo;
        end
        S_SCAN: begin
          if (w_h_end) begin
            r_hcount <= r_xlo;
            if (!w_v_end) r_vcount <= r_vcount + 1'b1;
          end else begin
            r_hcount <= r_hcount + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRI_BBOX_PIXEL_CENTER_EN
  assign w_x_fix = {{(XWIDTH-FRAC-HBITS){1'b0}}, r_hcount, 1'b1, {(FRAC-1){1'b0}}};
  assign w_y_fix = {{(YWIDTH-FRAC-VBITS){1'b0}}, r_vcount, 1'b1, {(FRAC-1){1'b0}}};
`else
  assign w_x_fix = {{(XWIDTH-FRAC-HBITS){1'b0}}, r_hcount, {FRAC{1'b0}}};
  assign w_y_fix = {{(YWIDTH-FRAC-VBITS){1'b0}}, r_vcount, {FRAC{1'b0}}};
`endif

  assign pix_valid_out = (r_state == S_SCAN);
  assign last_out      = pix_valid_out && w_h_end && w_v_end;
  assign x_out         = pix_valid_out ? w_x_fix : '0;
  assign y_out         = pix_valid_out ? w_y_fix : '0;
  assign hcount_out    = r_hcount;
  assign vcount_out    = r_vcount;
  assign x_tri_out     = r_x_tri;
  assign y_tri_out     = r_y_tri;
  assign iarea_out     = r_iarea;

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Scoreboard bench for tri_bbox_scanner: directed triangles push expected pixels,
// a negedge monitor pops and compares every presented pixel.
module tb_tri_bbox_scanner;
  localparam int XW = 24, YW = 24, FRAC = 14, AW = 16, HB = 9, VB = 8;

  logic clk = 1'b0, rst_n = 1'b0, freeze = 1'b0, tri_valid = 1'b0;
  logic [2:0][XW-1:0] x_tri = '0;
  logic [2:0][YW-1:0] y_tri = '0;
  logic [AW-1:0]      iarea = '0;
  logic               tri_ready, pix_valid, last;
  logic [XW-1:0]      x_o;
  logic [YW-1:0]      y_o;
  logic [HB-1:0]      hcount;
  logic [VB-1:0]      vcount;
  logic [2:0][XW-1:0] x_tri_o;
  logic [2:0][YW-1:0] y_tri_o;
  logic [AW-1:0]      iarea_o;

  tri_bbox_scanner dut (
    .clk_in(clk), .rst_n_in(rst_n), .freeze(freeze),
    .tri_valid_in(tri_valid), .tri_ready_out(tri_ready),
    .x_tri_in(x_tri), .y_tri_in(y_tri), .iarea_in(iarea),
    .x_out(x_o), .y_out(y_o), .hcount_out(hcount), .vcount_out(vcount),
    .x_tri_out(x_tri_o), .y_tri_out(y_tri_o), .iarea_out(iarea_o),
    .pix_valid_out(pix_valid), .last_out(last)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [HB-1:0] h; logic [VB-1:0] v; logic lst;} pix_t;
  pix_t exp_q[$];
  int n_chk = 0, n_fail = 0, n_pix = 0;
  logic [2:0][XW-1:0] exp_xt;
  logic [2:0][YW-1:0] exp_yt;
  logic [AW-1:0]      exp_ia;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [XW-1:0] fx(input int q4);
    int t;
    t = q4 * (1 << (FRAC - 2));
    return t[XW-1:0];
  endfunction

  task automatic push_box(input int xlo, input int xhi, input int ylo, input int yhi);
    pix_t p;
    for (int v = ylo; v <= yhi; v++)
      for (int h = xlo; h <= xhi; h++) begin
        p.h = h[HB-1:0];
        p.v = v[VB-1:0];
        p.lst = (h == xhi) && (v == yhi);
        exp_q.push_back(p);
      end
  endtask

  // Vertex coordinates are in quarter-pixel units.
  task automatic send_tri(input int x0, input int x1, input int x2,
                          input int y0, input int y1, input int y2, input logic [AW-1:0] ia);
    logic ok;
    x_tri[0] = fx(x0); x_tri[1] = fx(x1); x_tri[2] = fx(x2);
    y_tri[0] = fx(y0); y_tri[1] = fx(y1); y_tri[2] = fx(y2);
    iarea = ia;
    exp_xt = x_tri; exp_yt = y_tri; exp_ia = ia;
    n_pix = 0;
    tri_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tri_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", {95'b0, ok}, 96'd1);
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int npix);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check({nm, "_timeout"}, {95'b0, ok}, 96'd1);
    check({nm, "_ready_after_last"}, {95'b0, tri_ready}, 96'd1);
    check({nm, "_pix_count"}, n_pix, npix);
  endtask

  task automatic wait_pix(input int n);
    for (int i = 0; i < 500 && n_pix < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    pix_t p;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    if (rst_n && !freeze && pix_valid) begin
      n_pix++;
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", {hcount, vcount}, '1);
      end else begin
        p = exp_q.pop_front();
        ex = '0; ex[FRAC +: HB] = p.h;
        ey = '0; ey[FRAC +: VB] = p.v;
`ifdef TRI_BBOX_PIXEL_CENTER_EN
        ex[FRAC-1] = 1'b1;
        ey[FRAC-1] = 1'b1;
`endif
        check("hcount", hcount, p.h);
        check("vcount", vcount, p.v);
        check("last", last, p.lst);
        check("x_out", x_o, ex);
        check("y_out", y_o, ey);
        check("x_tri_out", x_tri_o, exp_xt);
        check("y_tri_out", y_tri_o, exp_yt);
        check("iarea_out", iarea_o, exp_ia);
      end
    end
  end

  initial begin
    int h0;
    #2;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_last", last, 0);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_x_out", x_o, 0);
    check("rst_y_out", y_o, 0);
    check("rst_x_tri", x_tri_o, 0);
    check("rst_iarea", iarea_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", tri_ready, 1);

    // 1: basic 4x4 box with first-pixel latency
    push_box(2, 5, 1, 4);
    send_tri(8, 20, 8, 4, 4, 16, 16'h0100);
    check("t1_setup_ready", tri_ready, 0);
    @(posedge clk); #1;
    check("t1_clip_valid", pix_valid, 0);
    @(posedge clk); #1;
    check("t1_first_valid", pix_valid, 1);
    wait_done("t1", 16);

    // 2: fully left of screen
    send_tri(-36, -12, -20, 4, 8, 12, 16'h0100);
    check("t2_ready_c1", tri_ready, 0);
    @(posedge clk); #1;
    check("t2_ready_c2", tri_ready, 0);
    @(posedge clk); #1;
    check("t2_ready_c3", tri_ready, 1);
    repeat (5) @(posedge clk); #1;
    check("t2_pix_count", n_pix, 0);

    // fractional and negative vertices floor correctly
    push_box(0, 3, 0, 2);
    send_tri(7, 13, -2, 2, 11, 4, 16'hfff0);
    wait_done("tfrac", 12);

    // 3: wide triangle clamped horizontally
    push_box(0, 319, 10, 11);
    send_tri(-12, 1600, 40, 40, 44, 42, 16'h0004);
    wait_done("t3", 640);

    // freeze while idle drops ready
    freeze = 1'b1; #1;
    check("idle_freeze_ready", tri_ready, 0);
    @(posedge clk); #1 freeze = 1'b0;

    // 4: freeze mid-scan
    push_box(2, 5, 1, 4);
    send_tri(8, 20, 8, 4, 4, 16, 16'h0100);
    wait_pix(6);
    freeze = 1'b1;
    h0 = int'(hcount);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_frozen_hcount", hcount, h0);
      check("t4_frozen_valid", pix_valid, 1);
    end
    freeze = 1'b0;
    wait_done("t4", 16);

    // 5: reset mid-scan
    push_box(2, 5, 1, 4);
    send_tri(8, 20, 8, 4, 4, 16, 16'h0100);
    wait_pix(7);
    rst_n = 1'b0; #1;
    check("t5_rst_valid", pix_valid, 0);
    check("t5_rst_hcount", hcount, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("t5_ready", tri_ready, 1);
    check("t5_pix_count", n_pix, 7);

    // 6: degenerate triangle (iarea 0)
    send_tri(8, 20, 8, 4, 4, 16, 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_ready", tri_ready, 1);
    repeat (5) @(posedge clk); #1;
    check("t6_pix_count", n_pix, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
